packet_assembler: RTL and testbench

PACKET_ASSEMBLER -- requirements
Module: packet_assembler

---
 rtl/packet_assembler.sv | 183 ++++++++++++++++++
 tb/tb_packet_assembler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
// packet_assembler: captures reward-stage packet fields, waits for the packet's timeslot and
// serializes it on a valid/ready word stream. Optional trailing XOR checksum: PKT_CHECKSUM_EN.
module packet_assembler #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load,
    input  logic [2:0]            rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic [5:0]            rTimeslot,
    input  logic                  frameStart,
    input  logic                  slotTick,
    input  logic                  txReady,
    output logic [WORD_WIDTH-1:0] txData,
    output logic                  txValid,
    output logic                  txLast,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            dropCount
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        SEND,
        DONE
    } state_e;

    typedef struct packed {
        logic [2:0]            ptype;
        logic [5:0]            timeslot;
        logic [WORD_WIDTH-1:0] source_id;
        logic [WORD_WIDTH-1:0] dest_id;
        logic [WORD_WIDTH-1:0] source_hops;
        logic [WORD_WIDTH-1:0] q_value;
        logic [WORD_WIDTH-1:0] energy_left;
        logic [WORD_WIDTH-1:0] chosen_ch;
        logic [WORD_WIDTH-1:0] hops_from_ch;
    } pkt_t;

    localparam logic [2:0] TYPE_HEARTBEAT = 3'b000;
    localparam logic [2:0] TYPE_INVALID   = 3'b111;

`ifdef PKT_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX_HB   = 4'd6;
    localparam logic [3:0] LAST_IDX_FULL = 4'd8;
`else
    localparam logic [3:0] LAST_IDX_HB   = 4'd5;
    localparam logic [3:0] LAST_IDX_FULL = 4'd7;
`endif

    state_e                state_q, state_d;
    pkt_t                  pkt_q, pkt_d;
    logic [3:0]            idx_q, idx_d;
    logic [5:0]            slot_cnt_q, slot_cnt_d;
    logic [7:0]            drop_q, drop_d;

    logic [WORD_WIDTH-1:0] words [8];
    logic [WORD_WIDTH-1:0] cur_word;
    logic [3:0]            last_idx;
    logic                  rejected;

    always_comb begin
        words[0] = {pkt_q.ptype, {(WORD_WIDTH-9){1'b0}}, pkt_q.timeslot};
        words[1] = pkt_q.source_id;
        words[2] = pkt_q.dest_id;
        words[3] = pkt_q.source_hops;
        words[4] = pkt_q.q_value;
        words[5] = pkt_q.energy_left;
        words[6] = pkt_q.chosen_ch;
        words[7] = pkt_q.hops_from_ch;
    end

    always_comb begin
        last_idx = (pkt_q.ptype == TYPE_HEARTBEAT) ? LAST_IDX_HB : LAST_IDX_FULL;
        cur_word = '0;
        if (!idx_q[3]) begin
            cur_word = words[idx_q[2:0]];
        end
`ifdef PKT_CHECKSUM_EN
        begin
            logic [WORD_WIDTH-1:0] csum;
            csum = words[0] ^ words[1] ^ words[2] ^ words[3] ^ words[4] ^ words[5];
            if (pkt_q.ptype != TYPE_HEARTBEAT) begin
                csum = csum ^ words[6] ^ words[7];
            end
            if (idx_q == last_idx) begin
                cur_word = csum;
            end
        end
`endif
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        slot_cnt_d = slot_cnt_q;

        if (frameStart) begin
            slot_cnt_d = '0;
        end else if (slotTick) begin
            slot_cnt_d = slot_cnt_q + 6'd1;
        end

        rejected = load && ((state_q != IDLE) || (rPacketType == TYPE_INVALID));
        if (rejected && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (load && (rPacketType != TYPE_INVALID)) begin
                    pkt_d = '{ptype:        rPacketType,
                              timeslot:     rTimeslot,
                              source_id:    rSourceID,
                              dest_id:      rDestinationID,
                              source_hops:  rSourceHops,
                              q_value:      rQValue,
                              energy_left:  rEnergyLeft,
                              chosen_ch:    rChosenCH,
                              hops_from_ch: rHopsFromCH};
                    idx_d   = '0;
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (slot_cnt_q == pkt_q.timeslot) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // Index only moves on an accepted word, which keeps txData stable under stall.
                if (txReady) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    // NOTE: the holding registers are ordinary flops, so they are cleared by reset like the rest of the state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            pkt_q      <= '0;
            idx_q      <= '0;
            slot_cnt_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            drop_q     <= drop_d;
        end
    end

    // Outputs decode registered state only: no combinational path from txReady.
    assign txValid   = (state_q == SEND);
    assign txLast    = txValid && (idx_q == last_idx);
    assign txData    = txValid ? cur_word : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dropCount = drop_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: a reference model queues the expected word stream
// per load, and an independent monitor pops and compares every accepted word.
module tb_packet_assembler;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         load = 1'b0;
    logic [2:0]   r_type = '0;
    logic [W-1:0] r_src = '0, r_dst = '0, r_hops = '0, r_q = '0, r_e = '0, r_ch = '0, r_hch = '0;
    logic [5:0]   r_ts = '0;
    logic         frame_start = 1'b0, slot_tick = 1'b0, tx_ready = 1'b1;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_last, busy, done;
    logic [7:0]   drop_count;

    packet_assembler #(.WORD_WIDTH(W)) dut (
        .clk(clk), .nrst(nrst), .load(load),
        .rPacketType(r_type), .rSourceID(r_src), .rDestinationID(r_dst),
        .rSourceHops(r_hops), .rQValue(r_q), .rEnergyLeft(r_e),
        .rChosenCH(r_ch), .rHopsFromCH(r_hch), .rTimeslot(r_ts),
        .frameStart(frame_start), .slotTick(slot_tick), .txReady(tx_ready),
        .txData(tx_data), .txValid(tx_valid), .txLast(tx_last),
        .busy(busy), .done(done), .dropCount(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           drop_model = 0;
    logic [W-1:0] fld [7];
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet as a list of words built straight from the field layout.
    function automatic void push_packet(input logic [2:0] t, input logic [5:0] ts);
        logic [W-1:0] w[$];
        logic [W-1:0] x;
        exp_t         e;
        int           n;
        w.push_back({t, 7'b0, ts});
        for (int i = 0; i < 7; i++) w.push_back(fld[i]);
        n = (t == 3'b000) ? 6 : 8;
        x = '0;
        for (int i = 0; i < n; i++) begin
            x ^= w[i];
            e.data = w[i];
`ifdef PKT_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (i == n - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef PKT_CHECKSUM_EN
        e.data = x;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < 7; i++) fld[i] = W'($urandom);
    endtask

    task automatic do_load(input logic [2:0] t, input logic [5:0] ts, input bit accept);
        @(posedge clk); #1;
        if (accept) push_packet(t, ts);
        else if (drop_model < 255) drop_model++;
        load = 1'b1; r_type = t; r_ts = ts;
        r_src = fld[0]; r_dst = fld[1]; r_hops = fld[2]; r_q = fld[3];
        r_e = fld[4]; r_ch = fld[5]; r_hch = fld[6];
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 slot_tick = 1'b1;
        @(posedge clk); #1 slot_tick = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check({name, "_done_seen"}, 32'(n < budget), 32'd1);
        check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (tx_valid) break;
            n++;
        end
        check({name, "_valid_seen"}, 32'(n < budget), 32'd1);
    endtask

    // Random back-pressure, active only when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: accepted words against the scoreboard, stall stability, done timing.
    initial begin
        logic         pv, pr, pl, exp_done;
        logic [W-1:0] pd;
        exp_t         e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; exp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                pv = 1'b0;
                exp_done = 1'b0;
                continue;
            end
            if (exp_done || done) begin
                check("done_pulse", 32'(done), 32'(exp_done));
                check("done_no_valid", 32'(tx_valid), 32'd0);
            end
            if (pv && !pr) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(pd));
                check("stall_last", 32'(tx_last), 32'(pl));
            end
            if (!tx_valid) check("idle_outputs_zero", {15'd0, tx_last, tx_data}, 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(tx_data), 32'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(tx_data), 32'(e.data));
                    check("word_last", 32'(tx_last), 32'(e.last));
                end
            end
            exp_done = tx_valid && tx_ready && tx_last;
            pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
        end
    end

    initial begin
        logic [2:0] t;
        logic [5:0] ts;
        bit         saw_done;

        // Reset before any clock edge.
        #1 nrst = 1'b0;
        #2;
        check("rst_outputs", {tx_data, 11'd0, tx_valid, tx_last, busy, done, 1'b0},
              32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        #20 nrst = 1'b1;

        // Heartbeat, timeslot 0 right after frameStart.
        tx_ready = 1'b1;
        pulse_frame();
        fld[0] = 16'h000C; fld[1] = 16'h0000; fld[2] = 16'h0001;
        fld[3] = 16'h1234; fld[4] = 16'h5678; fld[5] = 16'hAAAA; fld[6] = 16'h5555;
        do_load(3'b000, 6'd0, 1'b1);
        check("hb_busy", 32'(busy), 32'd1);
        wait_done("hb", 20);

        // Type 001, timeslot 3: no word before the third slotTick.
        pulse_frame();
        rand_fields();
        do_load(3'b001, 6'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("wait_slot_hold", 32'(tx_valid), 32'd0);
            end
            repeat (2) @(posedge clk);
            pulse_tick();
        end
        wait_done("ts3", 30);

        // frameStart wins over a simultaneous slotTick.
        pulse_frame();
        pulse_tick();
        pulse_tick();
        @(posedge clk); #1 frame_start = 1'b1; slot_tick = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0; slot_tick = 1'b0;
        rand_fields();
        do_load(3'b010, 6'd0, 1'b1);
        wait_done("frame_wins", 20);

        // Stall pattern 1,0,0,1 during SEND.
        pulse_frame();
        rand_fields();
        tx_ready = 1'b1;
        do_load(3'b100, 6'd0, 1'b1);
        wait_valid("stall", 10);
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done("stall", 20);

        // Drops: invalid type in IDLE, then two loads while a packet is in flight.
        pulse_frame();
        rand_fields();
        do_load(3'b111, 6'd0, 1'b0);
        check("drop_invalid", 32'(drop_count), 32'd1);
        rand_fields();
        do_load(3'b011, 6'd0, 1'b1);
        wait_valid("drop", 10);
        @(posedge clk); #1 tx_ready = 1'b0;
        rand_fields();
        do_load(3'b101, 6'd1, 1'b0);
        do_load(3'b000, 6'd2, 1'b0);
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done("drop", 20);
        check("drop_three", 32'(drop_count), 32'd3);

        // Reset mid-SEND; afterwards slotCount must be 0 again.
        pulse_frame();
        pulse_tick();
        pulse_tick();
        rand_fields();
        do_load(3'b110, 6'd2, 1'b1);
        wait_valid("rst_mid", 10);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rst_mid_outputs", {tx_data, 12'd0, tx_valid, tx_last, busy, done}, 32'd0);
        check("rst_mid_drop", 32'(drop_count), 32'd0);
        exp_q.delete();
        drop_model = 0;
        @(negedge clk);
        #2 nrst = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || tx_valid) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        rand_fields();
        do_load(3'b001, 6'd0, 1'b1);
        wait_done("after_rst", 20);

        // Randomized packets with back-pressure and stray loads.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            pulse_frame();
            rand_fields();
            if ($urandom_range(0, 3) == 0) do_load(3'b111, 6'($urandom_range(0, 7)), 1'b0);
            t  = 3'($urandom_range(0, 6));
            ts = 6'($urandom_range(0, 5));
            rand_fields();
            do_load(t, ts, 1'b1);
            for (int k = 0; k < int'(ts); k++) pulse_tick();
            if ($urandom_range(0, 1) == 1) do_load(3'($urandom_range(0, 7)), 6'd0, 1'b0);
            wait_done("rand", 200);
            check("rand_drop", 32'(drop_count), 32'(drop_model));
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;

        // dropCount saturates.
        for (int k = 0; k < 260; k++) do_load(3'b111, 6'd0, 1'b0);
        check("drop_saturate", 32'(drop_count), 32'(drop_model));
        check("drop_saturate_ff", 32'(drop_count), 32'hFF);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
